branch_unit_pred: RTL and testbench



---
 rtl/branch_unit_pred_pkg.sv | 23 ++
 rtl/branch_unit_pred_bht_2bit.sv | 64 ++++++
 rtl/branch_unit_pred.sv | 121 ++++++++++++
 tb/tb_branch_unit_pred.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/branch_unit_pred_pkg.sv
// Shared definitions for the branch unit: branch-control encoding and BHT constants.
// Imported by the top-level comparator and by the BHT sub-module.
package branch_unit_pred_pkg;

  localparam logic [2:0] BR_NONE  = 3'd0;
  localparam logic [2:0] BR_EQ    = 3'd1;
  localparam logic [2:0] BR_NE    = 3'd2;
  localparam logic [2:0] BR_LT    = 3'd3;
  localparam logic [2:0] BR_GE    = 3'd4;
  localparam logic [2:0] BR_LTU   = 3'd5;
  localparam logic [2:0] BR_GEU   = 3'd6;
  localparam logic [2:0] BR_NONE7 = 3'd7;

  // Weakly not-taken: one taken branch is enough to flip the prediction.
  localparam logic [1:0] BHT_RST_VAL = 2'b01;
  localparam logic [1:0] BHT_MAX     = 2'b11;
  localparam logic [1:0] BHT_MIN     = 2'b00;

  function automatic logic is_branch_ctrl(input logic [2:0] ctrl);
    return (ctrl >= BR_EQ) && (ctrl <= BR_GEU);
  endfunction

endpackage

// File: rtl/branch_unit_pred_bht_2bit.sv
// Branch history table of 2-bit saturating counters: combinational read,
// single saturating update port, synchronous reset of every entry to weakly not-taken.
module bht_2bit
  import branch_unit_pred_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 64,
  parameter int IDX_LSB = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_taken,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic            wr_taken
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]       ctr_reg [DEPTH];
  logic [DEPTH-1:0] wr_sel;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       cur_ctr;
  logic [1:0]       ctr_next;
  logic             unused_pc_bits;

  assign rd_idx = rd_pc[IDX_LSB +: IDX_W];
  assign wr_idx = wr_pc[IDX_LSB +: IDX_W];
  // Upper PC bits intentionally alias onto the same entries.
  assign unused_pc_bits = ^{rd_pc, wr_pc};

  // No write-to-read bypass: a same-cycle update is seen on the next cycle.
  assign rd_taken = ctr_reg[rd_idx][1];

  always_comb begin
    cur_ctr  = ctr_reg[wr_idx];
    ctr_next = cur_ctr;
    if (wr_taken) begin
      if (cur_ctr != BHT_MAX) ctr_next = cur_ctr + 2'b01;
    end else begin
      if (cur_ctr != BHT_MIN) ctr_next = cur_ctr - 2'b01;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_sel
      assign wr_sel[gi] = wr_en && (wr_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ctr_reg[i] <= BHT_RST_VAL;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) ctr_reg[i] <= ctr_next;
      end
    end
  end

endmodule

// File: rtl/branch_unit_pred.sv
// EX-stage branch resolver: six RV32I conditional compares, registered outcome,
// mispredict flag against an owned 2-bit BHT, and saturating branch/mispredict counters.
module branch_unit_pred
  import branch_unit_pred_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int IDX_LSB   = 2,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_a,
  input  logic [XLEN-1:0]  ex_b,
  input  logic [2:0]       ex_br_ctrl,
  input  logic             ex_pred_taken,
  output logic             br_valid,
  output logic             br_true,
  output logic             br_mispredict,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);

  logic            signed_cmp;
  logic [XLEN:0]   a_ext;
  logic [XLEN:0]   b_ext;
  logic [XLEN:0]   diff;
  logic            lt;
  logic            eq;
  logic            taken;
  logic            is_br;
  logic            mispredict;
  logic            upd_en;

  logic             br_valid_reg, br_valid_next;
  logic             br_true_reg, br_true_next;
  logic             br_mis_reg, br_mis_next;
  logic [CNT_W-1:0] br_cnt_reg, br_cnt_next;
  logic [CNT_W-1:0] mis_cnt_reg, mis_cnt_next;

  // One extra bit makes the borrow the true sign of a-b, so signed overflow cannot flip lt.
  always_comb begin
    signed_cmp = (ex_br_ctrl == BR_LT) || (ex_br_ctrl == BR_GE);
    a_ext      = {signed_cmp & ex_a[XLEN-1], ex_a};
    b_ext      = {signed_cmp & ex_b[XLEN-1], ex_b};
    diff       = a_ext - b_ext;
    lt         = diff[XLEN];
    eq         = (ex_a == ex_b);
    taken      = 1'b0;
    case (ex_br_ctrl)
      BR_EQ:             taken = eq;
      BR_NE:             taken = !eq;
      BR_LT, BR_LTU:     taken = lt;
      BR_GE, BR_GEU:     taken = !lt;
      default:           taken = 1'b0;
    endcase
  end

  assign is_br      = ex_valid && is_branch_ctrl(ex_br_ctrl);
  assign mispredict = is_br && (taken != ex_pred_taken);
  assign upd_en     = is_br && !ex_stall;

  always_comb begin
    br_valid_next = br_valid_reg;
    br_true_next  = br_true_reg;
    br_mis_next   = br_mis_reg;
    br_cnt_next   = br_cnt_reg;
    mis_cnt_next  = mis_cnt_reg;
    if (!ex_stall) begin
      br_valid_next = is_br;
      br_true_next  = is_br && taken;
      br_mis_next   = mispredict;
      if (is_br && (br_cnt_reg != {CNT_W{1'b1}}))
        br_cnt_next = br_cnt_reg + CNT_W'(1);
      if (mispredict && (mis_cnt_reg != {CNT_W{1'b1}}))
        mis_cnt_next = mis_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_valid_reg <= 1'b0;
      br_true_reg  <= 1'b0;
      br_mis_reg   <= 1'b0;
      br_cnt_reg   <= '0;
      mis_cnt_reg  <= '0;
    end else begin
      br_valid_reg <= br_valid_next;
      br_true_reg  <= br_true_next;
      br_mis_reg   <= br_mis_next;
      br_cnt_reg   <= br_cnt_next;
      mis_cnt_reg  <= mis_cnt_next;
    end
  end

  assign br_valid      = br_valid_reg;
  assign br_true       = br_true_reg;
  assign br_mispredict = br_mis_reg;
  assign br_cnt        = br_cnt_reg;
  assign mis_cnt       = mis_cnt_reg;

  bht_2bit #(
    .XLEN    (XLEN),
    .DEPTH   (BHT_DEPTH),
    .IDX_LSB (IDX_LSB)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_pc    (if_pc),
    .rd_taken (if_pred_taken),
    .wr_en    (upd_en),
    .wr_pc    (ex_pc),
    .wr_taken (taken)
  );

endmodule

// File: tb/tb_branch_unit_pred.sv
// Self-checking bench for branch_unit_pred: directed table plus randomized traffic
// compared against an array/arithmetic reference model; a CNT_W=4 copy exercises saturation.
module tb_branch_unit_pred;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        ex_valid, ex_stall, ex_pred_taken;
  logic [31:0] ex_pc, ex_a, ex_b;
  logic [2:0]  ex_br_ctrl;

  logic        if_pred_taken, br_valid, br_true, br_mispredict;
  logic [31:0] br_cnt, mis_cnt;
  logic        if_pred4, br_valid4, br_true4, br_mis4;
  logic [3:0]  br_cnt4, mis_cnt4;

  always #5 clk = ~clk;

  branch_unit_pred u_dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b),
    .ex_br_ctrl(ex_br_ctrl), .ex_pred_taken(ex_pred_taken),
    .br_valid(br_valid), .br_true(br_true), .br_mispredict(br_mispredict),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  branch_unit_pred #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred4),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b),
    .ex_br_ctrl(ex_br_ctrl), .ex_pred_taken(ex_pred_taken),
    .br_valid(br_valid4), .br_true(br_true4), .br_mispredict(br_mis4),
    .br_cnt(br_cnt4), .mis_cnt(mis_cnt4)
  );

  typedef struct {
    logic        rst, valid, stall;
    logic [2:0]  ctrl;
    logic [31:0] a, b, pc, ifpc;
    logic        pred;
    logic        e_v, e_t, e_m, e_if;
  } vec_t;

  int n_vec = 0;
  int n_mis = 0;
  int n_txn = 0;

  // Reference model state
  int          bht [64];
  int unsigned m_br, m_mis;
  logic        m_v, m_t, m_m;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int unsigned sat15(input int unsigned n);
    return (n > 15) ? 15 : n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s (txn %0d): got %0h expected %0h", name, n_txn, act, exp);
    end
  endtask

  task automatic model_step(input vec_t v);
    logic tk, isbr;
    if (v.rst) begin
      for (int i = 0; i < 64; i++) bht[i] = 1;
      m_br = 0; m_mis = 0;
      m_v = 0; m_t = 0; m_m = 0;
    end else if (!v.stall) begin
      case (v.ctrl)
        3'd1: tk = (v.a == v.b);
        3'd2: tk = (v.a != v.b);
        3'd3: tk = ($signed(v.a) <  $signed(v.b));
        3'd4: tk = ($signed(v.a) >= $signed(v.b));
        3'd5: tk = (v.a <  v.b);
        3'd6: tk = (v.a >= v.b);
        default: tk = 0;
      endcase
      isbr = v.valid && (v.ctrl >= 1) && (v.ctrl <= 6);
      m_v = isbr;
      m_t = isbr && tk;
      m_m = isbr && (tk != v.pred);
      if (isbr) begin
        if (tk && bht[idx_of(v.pc)] < 3) bht[idx_of(v.pc)]++;
        else if (!tk && bht[idx_of(v.pc)] > 0) bht[idx_of(v.pc)]--;
        m_br++;
        if (m_m) m_mis++;
      end
    end
  endtask

  // use_tbl: outputs and prediction from the table row; otherwise from the model.
  task automatic apply(input vec_t v, input bit use_tbl, input bit chk_if);
    logic exp_if;
    rst = v.rst; ex_valid = v.valid; ex_stall = v.stall; ex_br_ctrl = v.ctrl;
    ex_a = v.a; ex_b = v.b; ex_pc = v.pc; if_pc = v.ifpc; ex_pred_taken = v.pred;
    #1;
    exp_if = use_tbl ? v.e_if : (bht[idx_of(v.ifpc)] >= 2);
    if (chk_if) check("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, exp_if});
    model_step(v);
    @(posedge clk);
    #1;
    n_txn++;
    $display("txn %0d rst=%0b v=%0b st=%0b ctrl=%0d pc=%h -> bv=%0b bt=%0b bm=%0b bc=%0d mc=%0d",
             n_txn, v.rst, v.valid, v.stall, v.ctrl, v.pc, br_valid, br_true, br_mispredict,
             br_cnt, mis_cnt);
    check("br_valid",      {31'd0, br_valid},      {31'd0, use_tbl ? v.e_v : m_v});
    check("br_true",       {31'd0, br_true},       {31'd0, use_tbl ? v.e_t : m_t});
    check("br_mispredict", {31'd0, br_mispredict}, {31'd0, use_tbl ? v.e_m : m_m});
    check("br_cnt",        br_cnt,  m_br);
    check("mis_cnt",       mis_cnt, m_mis);
    check("br_cnt_w4",     {28'd0, br_cnt4},  sat15(m_br));
    check("mis_cnt_w4",    {28'd0, mis_cnt4}, sat15(m_mis));
  endtask

  function automatic vec_t mk(input logic r, input logic vl, input logic st, input logic [2:0] c,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                              input logic pr, input logic [31:0] ifpc,
                              input logic ev, input logic et, input logic em, input logic eif);
    vec_t t;
    t.rst = r; t.valid = vl; t.stall = st; t.ctrl = c; t.a = a; t.b = b; t.pc = pc;
    t.pred = pr; t.ifpc = ifpc; t.e_v = ev; t.e_t = et; t.e_m = em; t.e_if = eif;
    return t;
  endfunction

  vec_t tbl [19];
  vec_t rv;

  initial begin
    // rst valid stall ctrl a b pc pred if_pc | v t m if
    tbl[0]  = mk(0,1,0,3'd3,32'h7FFF_FFFF,32'h8000_0000,32'h100,0,32'h40, 1,0,0,0);
    tbl[1]  = mk(0,1,0,3'd5,32'h7FFF_FFFF,32'h8000_0000,32'h100,0,32'h40, 1,1,1,0);
    tbl[2]  = mk(0,1,0,3'd1,32'd5,32'd5,32'h40,0,32'h40, 1,1,1,0);
    tbl[3]  = mk(0,1,0,3'd1,32'd5,32'd5,32'h40,1,32'h40, 1,1,0,1);
    tbl[4]  = mk(0,1,0,3'd1,32'd5,32'd5,32'h40,1,32'h40, 1,1,0,1);
    tbl[5]  = mk(0,1,0,3'd1,32'd5,32'd5,32'h40,1,32'h40, 1,1,0,1);
    tbl[6]  = mk(0,1,0,3'd1,32'd5,32'd6,32'h40,1,32'h40, 1,0,1,1);
    tbl[7]  = mk(0,1,0,3'd1,32'd5,32'd6,32'h40,1,32'h40, 1,0,1,1);
    tbl[8]  = mk(0,1,0,3'd1,32'd5,32'd6,32'h40,0,32'h40, 1,0,0,0);
    tbl[9]  = mk(0,1,0,3'd1,32'd5,32'd6,32'h40,0,32'h40, 1,0,0,0);
    tbl[10] = mk(0,1,0,3'd0,32'd5,32'd5,32'h40,0,32'h40, 0,0,0,0);
    tbl[11] = mk(0,1,0,3'd7,32'd5,32'd5,32'h40,0,32'h40, 0,0,0,0);
    tbl[12] = mk(0,1,0,3'd2,32'd1,32'd2,32'h80,0,32'h80, 1,1,1,0);
    tbl[13] = mk(0,1,1,3'd4,32'd3,32'hFFFF_FFFF,32'hC0,1,32'h180, 1,1,1,1);
    tbl[14] = mk(0,1,0,3'd4,32'd3,32'hFFFF_FFFF,32'hC0,1,32'hC0, 1,1,0,0);
    tbl[15] = mk(0,1,0,3'd7,32'd3,32'd3,32'hC0,0,32'hC0, 0,0,0,1);
    tbl[16] = mk(1,1,0,3'd6,32'd1,32'd2,32'h40,1,32'h40, 0,0,0,0);
    tbl[17] = mk(0,1,0,3'd1,32'd5,32'd5,32'h40,0,32'h40, 1,1,1,0);
    tbl[18] = mk(0,0,0,3'd1,32'd5,32'd5,32'h40,0,32'h40, 0,0,0,1);

    rst = 1; ex_valid = 0; ex_stall = 0; ex_br_ctrl = 0; ex_a = 0; ex_b = 0;
    ex_pc = 0; if_pc = 0; ex_pred_taken = 0;
    @(posedge clk); #1;

    // Reset, including reset asserted together with a stall
    apply(mk(1,0,0,3'd0,0,0,0,0,0, 0,0,0,0), 0, 0);
    apply(mk(1,1,1,3'd1,0,0,0,0,0, 0,0,0,0), 0, 0);

    for (int i = 0; i < 64; i++) begin
      if_pc = 32'(i * 4);
      #1;
      check("post_reset_pred", {31'd0, if_pred_taken}, {31'd0, bht[i] >= 2});
    end

    for (int i = 0; i < 19; i++) apply(tbl[i], 1, 1);

    // Randomized traffic; a few PCs so entries saturate and alias
    for (int i = 0; i < 400; i++) begin
      rv.rst   = ($urandom_range(0, 99) == 0);
      rv.valid = ($urandom_range(0, 9) < 8);
      rv.stall = ($urandom_range(0, 9) < 2);
      rv.ctrl  = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: begin rv.a = $urandom; rv.b = rv.a; end
        1: begin rv.a = 32'h7FFF_FFFF; rv.b = 32'h8000_0000 + 32'($urandom_range(0, 1)); end
        2: begin rv.a = 32'($urandom_range(0, 3)); rv.b = 32'($urandom_range(0, 3)); end
        default: begin rv.a = $urandom; rv.b = $urandom; end
      endcase
      if ($urandom_range(0, 1) == 1) begin
        logic [31:0] t;
        t = rv.a; rv.a = rv.b; rv.b = t;
      end
      rv.pc   = 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3) << 8);
      rv.ifpc = 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3) << 8);
      rv.pred = 1'($urandom_range(0, 1));
      rv.e_v = 0; rv.e_t = 0; rv.e_m = 0; rv.e_if = 0;
      apply(rv, 0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
